// File: rtl/kmeans_regs_pkg.sv
// Shared definitions for the k-means register file and its APB initiator:
// register map, APB state encoding and default widths.
package kmeans_regs_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 91;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int TIMEOUT_DEF    = 16;

    typedef enum logic [7:0] {
        REG_INTERNAL_STATUS = 8'd0,
        REG_GO              = 8'd1,
        REG_CENT_1          = 8'd2,
        REG_CENT_2          = 8'd3,
        REG_CENT_3          = 8'd4,
        REG_CENT_4          = 8'd5,
        REG_CENT_5          = 8'd6,
        REG_CENT_6          = 8'd7,
        REG_CENT_7          = 8'd8,
        REG_CENT_8          = 8'd9,
        REG_RAM_ADDR        = 8'd10,
        REG_RAM_DATA        = 8'd11,
        REG_FIRST_RAM_ADDR  = 8'd12,
        REG_LAST_RAM_ADDR   = 8'd13
    } kmeans_reg_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/kmeans_apb_master_if.sv
// Command, APB and response signals of the k-means APB initiator.
interface kmeans_apb_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 91
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        output cmd_ready, paddr, pwrite, psel, penable, pwdata,
               rsp_valid, rsp_write, rsp_rdata, rsp_err, busy
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        input  cmd_ready, paddr, pwrite, psel, penable, pwdata,
               rsp_valid, rsp_write, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/kmeans_cmd_fifo.sv
// Synchronous command FIFO; power-of-two depth so pointers wrap naturally.
module kmeans_cmd_fifo #(
    parameter int WIDTH = 100,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/kmeans_apb_master.sv
// APB initiator: buffers host commands and issues them as SETUP/ACCESS transfers.
// IDLE: bus idle, waiting for FIFO | SETUP: psel only | ACCESS: psel+penable, wait pready
module kmeans_apb_master
    import kmeans_regs_pkg::*;
#(
    parameter int addrWidth  = ADDR_W_DEF,
    parameter int dataWidth  = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    kmeans_apb_master_if.master ifc
);
    localparam int ENTRY_W = 1 + addrWidth + dataWidth;
    localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    apb_state_e           r_state;
    logic [addrWidth-1:0] r_paddr;
    logic                 r_pwrite;
    logic                 r_psel;
    logic                 r_penable;
    logic [dataWidth-1:0] r_pwdata;
    logic                 r_rsp_valid;
    logic                 r_rsp_write;
    logic [dataWidth-1:0] r_rsp_rdata;
    logic                 r_rsp_err;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [ENTRY_W-1:0]   w_head;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_timeout;

    assign ifc.cmd_ready = rst_n && !w_full;
    assign w_push        = ifc.cmd_valid && ifc.cmd_ready;
    assign w_pop         = !w_empty && ((r_state == IDLE) || (r_state == ACCESS && ifc.pready));
    assign w_cnt_nxt     = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    assign w_timeout     = (TIMEOUT != 0) && (w_cnt_nxt >= TO_VAL);

    kmeans_cmd_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({ifc.cmd_write, ifc.cmd_addr, ifc.cmd_wdata}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_paddr     <= '0;
            r_pwrite    <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_pwrite  <= w_head[ENTRY_W-1];
                        r_paddr   <= w_head[dataWidth +: addrWidth];
                        r_pwdata  <= w_head[dataWidth-1:0];
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    r_cnt <= w_cnt_nxt;
                    if (ifc.pready) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_write <= r_pwrite;
                        r_rsp_rdata <= r_pwrite ? '0 : ifc.prdata;
                        r_penable   <= 1'b0;
                        if (!w_empty) begin
                            // chain straight into the next SETUP, psel stays high
                            r_pwrite <= w_head[ENTRY_W-1];
                            r_paddr  <= w_head[dataWidth +: addrWidth];
                            r_pwdata <= w_head[dataWidth-1:0];
                            r_cnt    <= '0;
                            r_state  <= SETUP;
                        end else begin
                            r_psel  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_write <= r_pwrite;
                        r_rsp_rdata <= '0;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign ifc.paddr     = r_paddr;
    assign ifc.pwrite    = r_pwrite;
    assign ifc.psel      = r_psel;
    assign ifc.penable   = r_penable;
    assign ifc.pwdata    = r_pwdata;
    assign ifc.rsp_valid = r_rsp_valid;
    assign ifc.rsp_write = r_rsp_write;
    assign ifc.rsp_rdata = r_rsp_rdata;
    assign ifc.rsp_err   = r_rsp_err;
    assign ifc.busy      = !w_empty || (r_state != IDLE);
endmodule

// File: tb/tb_kmeans_apb_master.sv
// Directed bench for kmeans_apb_master: latency, waits, queueing, timeout, reset.
module tb_kmeans_apb_master;
    import kmeans_regs_pkg::*;

    localparam logic [90:0] RD_VAL = 91'h5A;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    kmeans_apb_master_if #(.ADDR_W(8), .DATA_W(91)) ifc ();

    kmeans_apb_master #(
        .addrWidth  (8),
        .dataWidth  (91),
        .FIFO_DEPTH (4),
        .TIMEOUT    (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifc   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic w, input logic [7:0] a, input logic [90:0] d);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_write = w;
        ifc.cmd_addr  = a;
        ifc.cmd_wdata = d;
        tick();
        ifc.cmd_valid = 1'b0;
    endtask

    logic        q_w [5];
    logic [7:0]  q_a [5];
    logic [90:0] q_d [5];

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_write = 1'b0;
        ifc.cmd_addr  = '0;
        ifc.cmd_wdata = '0;
        ifc.prdata    = RD_VAL;
        ifc.pready    = 1'b0;
        tick();
        tick();
        chk("rst_psel", ifc.psel, 1'b0);
        chk("rst_penable", ifc.penable, 1'b0);
        chk("rst_apb_regs", {ifc.pwrite, ifc.paddr, ifc.pwdata}, '0);
        chk("rst_rsp", {ifc.rsp_valid, ifc.rsp_write, ifc.rsp_err, ifc.rsp_rdata}, '0);
        chk("rst_busy", ifc.busy, 1'b0);
        chk("rst_cmd_ready", ifc.cmd_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", ifc.cmd_ready, 1'b1);

        // single zero-wait write
        ifc.pready = 1'b1;
        push(1'b1, 8'(REG_RAM_ADDR), 91'd1);
        chk("w1_psel_e0", ifc.psel, 1'b0);
        chk("w1_busy", ifc.busy, 1'b1);
        tick();
        chk("w1_psel_e1", ifc.psel, 1'b1);
        chk("w1_penable_e1", ifc.penable, 1'b0);
        chk("w1_paddr", ifc.paddr, 8'd10);
        chk("w1_pwrite", ifc.pwrite, 1'b1);
        chk("w1_pwdata", ifc.pwdata, 91'd1);
        tick();
        chk("w1_penable_e2", ifc.penable, 1'b1);
        chk("w1_rsp_early", ifc.rsp_valid, 1'b0);
        tick();
        chk("w1_rsp_valid", ifc.rsp_valid, 1'b1);
        chk("w1_rsp_write", ifc.rsp_write, 1'b1);
        chk("w1_rsp_rdata", ifc.rsp_rdata, 91'd0);
        chk("w1_rsp_err", ifc.rsp_err, 1'b0);
        chk("w1_psel_end", ifc.psel, 1'b0);
        tick();
        chk("w1_rsp_drop", ifc.rsp_valid, 1'b0);
        chk("w1_idle_busy", ifc.busy, 1'b0);

        // read with two wait cycles
        ifc.pready = 1'b0;
        push(1'b0, 8'(REG_INTERNAL_STATUS), 91'd0);
        tick();
        chk("r2_psel", ifc.psel, 1'b1);
        chk("r2_pwrite", ifc.pwrite, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r2_penable", ifc.penable, 1'b1);
            chk("r2_paddr", ifc.paddr, 8'd0);
            chk("r2_no_rsp", ifc.rsp_valid, 1'b0);
        end
        ifc.pready = 1'b1;
        tick();
        chk("r2_rsp_valid", ifc.rsp_valid, 1'b1);
        chk("r2_rsp_rdata", ifc.rsp_rdata, RD_VAL);
        chk("r2_rsp_write", ifc.rsp_write, 1'b0);
        chk("r2_rsp_err", ifc.rsp_err, 1'b0);
        chk("r2_penable_end", ifc.penable, 1'b0);
        tick();

        // one stalled transfer plus four queued: fills the FIFO, then drains back-to-back
        q_w = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        q_a = '{8'd10, 8'd11, 8'd10, 8'd11, 8'd1};
        q_d = '{91'd1, 91'd6, 91'd2, 91'd12, 91'd0};
        ifc.pready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(q_w[i], q_a[i], q_d[i]);
            if (i == 3) chk("q_ready_3", ifc.cmd_ready, 1'b1);
        end
        chk("q_full_ready", ifc.cmd_ready, 1'b0);
        chk("q0_paddr", ifc.paddr, q_a[0]);
        chk("q0_pwdata", ifc.pwdata, q_d[0]);
        ifc.pready = 1'b1;
        tick();
        chk("q0_rsp", ifc.rsp_valid, 1'b1);
        chk("q0_chain_psel", ifc.psel, 1'b1);
        chk("q0_chain_penable", ifc.penable, 1'b0);
        chk("q_ready_rise", ifc.cmd_ready, 1'b1);
        for (int k = 1; k < 5; k++) begin
            tick();
            chk("q_access_psel", ifc.psel, 1'b1);
            chk("q_access_penable", ifc.penable, 1'b1);
            chk("q_access_paddr", ifc.paddr, q_a[k]);
            chk("q_access_pwdata", ifc.pwdata, q_d[k]);
            chk("q_access_pwrite", ifc.pwrite, q_w[k]);
            chk("q_gap_rsp", ifc.rsp_valid, 1'b0);
            tick();
            chk("q_rsp_valid", ifc.rsp_valid, 1'b1);
            chk("q_rsp_write", ifc.rsp_write, q_w[k]);
            chk("q_rsp_rdata", ifc.rsp_rdata, q_w[k] ? 91'd0 : RD_VAL);
            chk("q_psel_after", ifc.psel, (k < 4) ? 1'b1 : 1'b0);
        end
        tick();
        chk("q_idle_busy", ifc.busy, 1'b0);

        // timeout on a write to go, then a queued read completes
        ifc.pready = 1'b0;
        push(1'b1, 8'(REG_GO), 91'd1);
        push(1'b0, 8'(REG_LAST_RAM_ADDR), 91'd0);
        tick();
        chk("to_penable_start", ifc.penable, 1'b1);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk("to_wait_penable", ifc.penable, 1'b1);
            chk("to_wait_rsp", ifc.rsp_valid, 1'b0);
        end
        tick();
        chk("to_rsp_valid", ifc.rsp_valid, 1'b1);
        chk("to_rsp_err", ifc.rsp_err, 1'b1);
        chk("to_rsp_rdata", ifc.rsp_rdata, 91'd0);
        chk("to_rsp_write", ifc.rsp_write, 1'b1);
        chk("to_psel_drop", ifc.psel, 1'b0);
        ifc.pready = 1'b1;
        tick();
        chk("to_next_psel", ifc.psel, 1'b1);
        chk("to_next_paddr", ifc.paddr, 8'd13);
        chk("to_err_clear", ifc.rsp_err, 1'b0);
        tick();
        chk("to_next_penable", ifc.penable, 1'b1);
        tick();
        chk("to_next_rsp", ifc.rsp_valid, 1'b1);
        chk("to_next_err", ifc.rsp_err, 1'b0);
        chk("to_next_rdata", ifc.rsp_rdata, RD_VAL);
        tick();

        // reset during ACCESS with two commands still queued
        ifc.pready = 1'b0;
        push(1'b1, 8'(REG_CENT_1), 91'd3);
        push(1'b1, 8'(REG_CENT_2), 91'd4);
        push(1'b1, 8'(REG_CENT_3), 91'd5);
        tick();
        chk("rm_in_access", ifc.penable, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("rm_psel", ifc.psel, 1'b0);
        chk("rm_penable", ifc.penable, 1'b0);
        chk("rm_busy", ifc.busy, 1'b0);
        chk("rm_ready", ifc.cmd_ready, 1'b0);
        rst_n = 1'b1;
        ifc.pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rm_no_rsp", ifc.rsp_valid, 1'b0);
            chk("rm_flushed_psel", ifc.psel, 1'b0);
            chk("rm_flushed_busy", ifc.busy, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
